// File: rtl/if_fetch_unit_pkg.sv
// Shared types for the IF-stage fetch engine: FSM states, output slot record
// and a saturating add used by the optional performance counters.
package if_fetch_unit_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pred_target;
    logic [1:0]  pred_outcome;
    logic        btb_hit;
  } if_slot_t;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] n);
    logic [32:0] s;
    s = {1'b0, a} + {31'b0, n};
    return s[32] ? '1 : s[31:0];
  endfunction

endpackage

// File: rtl/if_fetch_unit_slot.sv
// One-entry IF/ID holding register; flush beats load, load beats consume.
module if_output_slot
  import if_fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        consume,
  input  logic        flush,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_target,
  input  logic [1:0]  load_outcome,
  input  logic        load_btb_hit,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] target,
  output logic [1:0]  outcome,
  output logic        btb_hit
);

  if_slot_t slot_q;

  // Flush and consume only drop valid; payload fields keep their last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= '0;
    end else if (flush) begin
      slot_q.valid <= 1'b0;
    end else if (load) begin
      slot_q.valid        <= 1'b1;
      slot_q.instr        <= load_instr;
      slot_q.pc           <= load_pc;
      slot_q.pred_target  <= load_target;
      slot_q.pred_outcome <= load_outcome;
      slot_q.btb_hit      <= load_btb_hit;
    end else if (consume) begin
      slot_q.valid <= 1'b0;
    end
  end

  assign valid   = slot_q.valid;
  assign instr   = slot_q.instr;
  assign pc      = slot_q.pc;
  assign target  = slot_q.pred_target;
  assign outcome = slot_q.pred_outcome;
  assign btb_hit = slot_q.btb_hit;

endmodule

// File: rtl/if_fetch_unit.sv
// IF-stage fetch engine: fetch PC, I-cache handshake, MEM redirects.
// Define IF_FETCH_PERF_EN to add perf_fetched / perf_squashed counters.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h00000060
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] if_pc_out,
  input  logic [31:0] pred_pcmux_out,
  input  logic [31:0] pred_target,
  input  logic [1:0]  pred_outcome,
  input  logic        pred_btb_hit,
  input  logic        mem_misprediction,
  input  logic [31:0] redirect_pc,
  output logic        icache_read,
  output logic [31:0] icache_address,
  input  logic [31:0] icache_rdata,
  input  logic        icache_resp,
  input  logic        stall_in,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_predicted_pcmux_out,
  output logic [1:0]  if_predicted_branch_outcome,
  output logic        if_BTB_hit
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_squashed
`endif
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pend_pc_q, pend_pc_d;
  logic         squash_q, squash_d;
  logic         slot_load;
  logic         consume;

  assign consume = if_valid && !stall_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      pend_pc_q <= '0;
      squash_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
      squash_q  <= squash_d;
    end
  end

  // A redirect during an outstanding read cannot cancel it; it is parked in
  // pend_pc and the stale response is dropped when it finally returns.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    squash_d  = squash_q;
    slot_load = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (mem_misprediction) begin
          pc_d    = redirect_pc;
          state_d = S_REQ;
        end else if (!if_valid || consume) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (icache_resp) begin
          state_d  = S_IDLE;
          squash_d = 1'b0;
          if (mem_misprediction) begin
            pc_d = redirect_pc;
          end else if (squash_q) begin
            pc_d = pend_pc_q;
          end else begin
            pc_d      = pred_pcmux_out;
            slot_load = 1'b1;
          end
        end else if (mem_misprediction) begin
          squash_d  = 1'b1;
          pend_pc_d = redirect_pc;
        end
      end
    endcase
  end

  assign if_pc_out      = pc_q;
  assign icache_address = pc_q;
  assign icache_read    = (state_q == S_REQ) && !rst;

  if_output_slot u_slot (
    .clk          (clk),
    .rst          (rst),
    .load         (slot_load),
    .consume      (consume),
    .flush        (mem_misprediction),
    .load_instr   (icache_rdata),
    .load_pc      (pc_q),
    .load_target  (pred_target),
    .load_outcome (pred_outcome),
    .load_btb_hit (pred_btb_hit),
    .valid        (if_valid),
    .instr        (if_instr),
    .pc           (if_pc),
    .target       (if_predicted_pcmux_out),
    .outcome      (if_predicted_branch_outcome),
    .btb_hit      (if_BTB_hit)
  );

`ifdef IF_FETCH_PERF_EN
  logic       resp_discard;
  logic [1:0] squash_inc;

  assign resp_discard = (state_q == S_REQ) && icache_resp && (squash_q || mem_misprediction);
  assign squash_inc   = {1'b0, resp_discard} + {1'b0, if_valid && mem_misprediction};

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched  <= '0;
      perf_squashed <= '0;
    end else begin
      if (slot_load) perf_fetched <= sat_add(perf_fetched, 2'd1);
      perf_squashed <= sat_add(perf_squashed, squash_inc);
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed vector table, reset-mid-request sequence,
// then randomized traffic against a transaction-level reference model.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc_out;
  logic [31:0] pred_pcmux_out, pred_target;
  logic [1:0]  pred_outcome;
  logic        pred_btb_hit;
  logic        mem_misprediction;
  logic [31:0] redirect_pc;
  logic        icache_read;
  logic [31:0] icache_address;
  logic [31:0] icache_rdata;
  logic        icache_resp;
  logic        stall_in;
  logic        if_valid;
  logic [31:0] if_instr, if_pc, if_predicted_pcmux_out;
  logic [1:0]  if_predicted_branch_outcome;
  logic        if_BTB_hit;
`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_squashed;
`endif

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(32'h00000060)) dut (
    .clk                         (clk),
    .rst                         (rst),
    .if_pc_out                   (if_pc_out),
    .pred_pcmux_out              (pred_pcmux_out),
    .pred_target                 (pred_target),
    .pred_outcome                (pred_outcome),
    .pred_btb_hit                (pred_btb_hit),
    .mem_misprediction           (mem_misprediction),
    .redirect_pc                 (redirect_pc),
    .icache_read                 (icache_read),
    .icache_address              (icache_address),
    .icache_rdata                (icache_rdata),
    .icache_resp                 (icache_resp),
    .stall_in                    (stall_in),
    .if_valid                    (if_valid),
    .if_instr                    (if_instr),
    .if_pc                       (if_pc),
    .if_predicted_pcmux_out      (if_predicted_pcmux_out),
    .if_predicted_branch_outcome (if_predicted_branch_outcome),
    .if_BTB_hit                  (if_BTB_hit)
`ifdef IF_FETCH_PERF_EN
    ,
    .perf_fetched                (perf_fetched),
    .perf_squashed               (perf_squashed)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    logic        stall, mis;
    logic [31:0] rpc;
    logic        resp;
    logic [31:0] rdata, pmux;
    logic [1:0]  pout;
    logic        phit;
    logic        e_read;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr, e_pc, e_tgt;
    logic [1:0]  e_out;
    logic        e_hit;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic mi, input logic [31:0] rp,
                              input logic rs, input logic [31:0] rd, input logic [31:0] pm,
                              input logic [1:0] po, input logic ph,
                              input logic er, input logic [31:0] ea, input logic ev,
                              input logic [31:0] ei, input logic [31:0] ep, input logic [31:0] et,
                              input logic [1:0] eo, input logic eh);
    vec_t v;
    v.stall = st; v.mis = mi; v.rpc = rp; v.resp = rs; v.rdata = rd; v.pmux = pm;
    v.pout = po; v.phit = ph; v.e_read = er; v.e_addr = ea; v.e_valid = ev;
    v.e_instr = ei; v.e_pc = ep; v.e_tgt = et; v.e_out = eo; v.e_hit = eh;
    return v;
  endfunction

  task automatic drive(input logic st, input logic mi, input logic [31:0] rp, input logic rs,
                       input logic [31:0] rd, input logic [31:0] pm, input logic [31:0] pt,
                       input logic [1:0] po, input logic ph);
    stall_in = st; mem_misprediction = mi; redirect_pc = rp; icache_resp = rs;
    icache_rdata = rd; pred_pcmux_out = pm; pred_target = pt; pred_outcome = po; pred_btb_hit = ph;
  endtask

  task automatic chk_outputs(input string tag, input logic e_read, input logic [31:0] e_addr,
                             input logic e_valid, input logic [31:0] e_instr, input logic [31:0] e_pc,
                             input logic [31:0] e_tgt, input logic [1:0] e_out, input logic e_hit);
    chk({tag, ".icache_read"}, {31'b0, icache_read}, {31'b0, e_read});
    chk({tag, ".icache_address"}, icache_address, e_addr);
    chk({tag, ".if_pc_out"}, if_pc_out, e_addr);
    chk({tag, ".if_valid"}, {31'b0, if_valid}, {31'b0, e_valid});
    if (e_valid) begin
      chk({tag, ".if_instr"}, if_instr, e_instr);
      chk({tag, ".if_pc"}, if_pc, e_pc);
      chk({tag, ".if_target"}, if_predicted_pcmux_out, e_tgt);
      chk({tag, ".if_outcome"}, {30'b0, if_predicted_branch_outcome}, {30'b0, e_out});
      chk({tag, ".if_btb_hit"}, {31'b0, if_BTB_hit}, {31'b0, e_hit});
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    chk("reset.icache_read", {31'b0, icache_read}, 32'd0);
    chk("reset.if_pc_out", if_pc_out, 32'h60);
    chk("reset.if_valid", {31'b0, if_valid}, 32'd0);
  endtask

  // Reference model: one fetch in flight at most; a redirect that lands while
  // it is in flight marks it stale and remembers where to go afterwards.
  typedef struct {
    logic        valid;
    logic [31:0] instr, pc, tgt;
    logic [1:0]  out;
    logic        hit;
  } mslot_t;

  logic        m_in_flight, m_stale;
  logic [31:0] m_pc, m_after_stale;
  mslot_t      m_slot;
  int unsigned m_fetched, m_dropped;

  task automatic model_cycle(input logic st, input logic mi, input logic [31:0] rp,
                             input logic rs, input logic [31:0] rd, input logic [31:0] pm,
                             input logic [31:0] pt, input logic [1:0] po, input logic ph);
    logic took, next_in_flight;
    took = m_slot.valid && !st;
    next_in_flight = m_in_flight;
    if (mi && m_slot.valid) m_dropped++;
    if (m_in_flight && rs) begin
      next_in_flight = 1'b0;
      if (mi || m_stale) begin
        m_dropped++;
        m_pc = mi ? rp : m_after_stale;
      end else begin
        m_fetched++;
        m_slot = '{valid: 1'b1, instr: rd, pc: m_pc, tgt: pt, out: po, hit: ph};
        took = 1'b0;
        m_pc = pm;
      end
      m_stale = 1'b0;
    end else if (m_in_flight && mi) begin
      m_stale = 1'b1;
      m_after_stale = rp;
    end else if (!m_in_flight) begin
      if (mi) m_pc = rp;
      if (mi || !m_slot.valid || took) next_in_flight = 1'b1;
    end
    if (mi || took) m_slot.valid = 1'b0;
    m_in_flight = next_in_flight;
  endtask

  vec_t tbl[$];

  initial begin
    logic        c_busy;
    int unsigned c_cnt;
    logic        st, mi, rs, ph;
    logic [31:0] rp, rd, pm, pt;
    logic [1:0]  po;

    do_reset();

    tbl.push_back(mk(0,0,0,0,0,0,0,0,                          0,32'h60,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,                          1,32'h60,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,1,32'hAAAA0001,32'h64,0,0,          1,32'h60,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,                          0,32'h64,1,32'hAAAA0001,32'h60,32'h64,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,                          1,32'h64,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,1,32'hBBBB0002,32'h200,2'b11,1,     1,32'h64,0,0,0,0,0,0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1,0,0,0,0,0,0,0,                        0,32'h200,1,32'hBBBB0002,32'h64,32'h200,2'b11,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,                          0,32'h200,1,32'hBBBB0002,32'h64,32'h200,2'b11,1));
    tbl.push_back(mk(0,1,32'h300,0,0,0,0,0,                    1,32'h200,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,32'h400,0,0,0,0,0,                    1,32'h200,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,                          1,32'h200,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,1,32'hDEAD0000,32'h999,0,0,         1,32'h200,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,                          0,32'h400,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,1,32'hCCCC0003,32'h404,2'b01,0,     1,32'h400,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,32'h500,0,0,0,0,0,                    0,32'h404,1,32'hCCCC0003,32'h400,32'h404,2'b01,0));
    tbl.push_back(mk(0,1,32'h600,1,32'h11,32'h504,0,0,         1,32'h500,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,                          0,32'h600,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,1,32'h22,32'hFFFFFFFC,0,0,          1,32'h600,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,                          0,32'hFFFFFFFC,1,32'h22,32'h600,32'hFFFFFFFC,0,0));
    tbl.push_back(mk(0,0,0,1,32'h33,32'h0,0,0,                 1,32'hFFFFFFFC,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,                          0,32'h0,1,32'h33,32'hFFFFFFFC,32'h0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,                          1,32'h0,0,0,0,0,0,0));

    foreach (tbl[i]) begin
      @(negedge clk);
      rst = 1'b0;
      drive(tbl[i].stall, tbl[i].mis, tbl[i].rpc, tbl[i].resp, tbl[i].rdata,
            tbl[i].pmux, tbl[i].pmux, tbl[i].pout, tbl[i].phit);
      #1;
      chk_outputs($sformatf("tbl[%0d]", i), tbl[i].e_read, tbl[i].e_addr, tbl[i].e_valid,
                  tbl[i].e_instr, tbl[i].e_pc, tbl[i].e_tgt, tbl[i].e_out, tbl[i].e_hit);
    end

    // Reset while a read is outstanding, then a late response in S_IDLE.
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("midreset.icache_read", {31'b0, icache_read}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 1, 32'hBAD0BAD0, 32'h700, 32'h700, 0, 0);
    #1;
    chk_outputs("midreset.idle", 0, 32'h60, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk_outputs("midreset.req", 1, 32'h60, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk_outputs("midreset.hold", 1, 32'h60, 0, 0, 0, 0, 0, 0);

    // Randomized traffic with a variable-latency cache.
    do_reset();
    m_in_flight = 1'b0; m_stale = 1'b0; m_pc = 32'h60; m_after_stale = '0;
    m_slot = '{valid: 1'b0, instr: '0, pc: '0, tgt: '0, out: '0, hit: 1'b0};
    m_fetched = 0; m_dropped = 0;
    c_busy = 1'b0; c_cnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      rst = 1'b0;
      st = ($urandom_range(0, 2) == 0);
      mi = ($urandom_range(0, 9) == 0);
      rp = $urandom & 32'hFFFFFFFC;
      pm = ($urandom_range(0, 1) == 0) ? m_pc + 32'd4 : ($urandom & 32'hFFFFFFFC);
      pt = $urandom & 32'hFFFFFFFC;
      po = 2'($urandom_range(0, 3));
      ph = 1'($urandom_range(0, 1));
      rd = $urandom;
      rs = 1'b0;
      if (c_busy) begin
        if (c_cnt == 1) begin
          rs = 1'b1;
          c_busy = 1'b0;
        end else begin
          c_cnt--;
        end
      end else if (m_in_flight) begin
        c_busy = 1'b1;
        c_cnt = $urandom_range(1, 4);
      end else if ($urandom_range(0, 15) == 0) begin
        rs = 1'b1;
      end
      drive(st, mi, rp, rs, rd, pm, pt, po, ph);
      #1;
      chk_outputs("rand", m_in_flight, m_pc, m_slot.valid, m_slot.instr, m_slot.pc,
                  m_slot.tgt, m_slot.out, m_slot.hit);
      model_cycle(st, mi, rp, rs, rd, pm, pt, po, ph);
    end
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
`ifdef IF_FETCH_PERF_EN
    chk("perf_fetched", perf_fetched, m_fetched);
    chk("perf_squashed", perf_squashed, m_dropped);
`endif
    chk("rand.fetch_progress", {31'b0, m_fetched > 100}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- IF-stage fetch engine directly upstream of the branch predictor.
- Owns the architectural fetch PC, presents it to the predictor as if_pc_out, and runs the I-cache read handshake.
- Takes the predictor's next PC and prediction metadata, packages each fetched instruction into a one-entry output slot for the IF/ID register, and applies MEM-stage misprediction redirects, including ones that arrive while a cache read is outstanding.

Parameters:
- RESET_PC, 32'h00000060, fetch address loaded on reset.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_pc_out  out  32  current fetch PC; predictor lookup index and I-cache address
- pred_pcmux_out  in  32  predictor's next-PC choice for if_pc_out
- pred_target  in  32  predictor BTB target for if_pc_out
- pred_outcome  in  2  predictor counter state for if_pc_out
- pred_btb_hit  in  1  BTB hit for if_pc_out
- mem_misprediction  in  1  redirect request from MEM
- redirect_pc  in  32  corrected PC, valid with mem_misprediction
- icache_read  out  1  read request
- icache_address  out  32  equals if_pc_out
- icache_rdata  in  32  instruction word
- icache_resp  in  1  read complete, one-cycle pulse
- stall_in  in  1  IF/ID cannot accept this cycle
- if_valid  out  1  slot holds a valid instruction
- if_instr  out  32  slot instruction
- if_pc  out  32  slot PC
- if_predicted_pcmux_out  out  32  slot predicted target
- if_predicted_branch_outcome  out  2  slot counter state
- if_BTB_hit  out  1  slot BTB hit

Behaviour:
- Reset values: pc_q=RESET_PC, state=S_IDLE, if_valid=0, squash=0, pend_pc=0, all slot fields 0. icache_read=0 while rst is high.
- Consume: the slot is consumed in any cycle where if_valid && !stall_in.
- S_IDLE: icache_read=0.
  - Go to S_REQ next cycle when the slot is empty or is being consumed this cycle.
- S_REQ: icache_read=1 and icache_address=pc_q.
  - pc_q and icache_address hold constant until icache_resp.
- Good response (icache_resp && !squash && !mem_misprediction):
  - Load the slot: instr=icache_rdata, pc=pc_q, target=pred_target, outcome=pred_outcome, hit=pred_btb_hit.
  - if_valid <= 1 and pc_q <= pred_pcmux_out.
  - Next state S_IDLE.
- Latency: the instruction is visible one cycle after icache_resp.
  - Peak throughput is one instruction per 3 cycles with a 1-cycle cache.
  - A request is never launched while the slot could still be full at response time.
- Redirect (mem_misprediction), highest priority in every state:
  - if_valid <= 0. This wins over a same-cycle consume and over a same-cycle good response.
  - S_IDLE: pc_q <= redirect_pc, then go to S_REQ.
  - S_REQ with icache_resp in the same cycle: discard the data, pc_q <= redirect_pc, go to S_IDLE.
  - S_REQ without icache_resp: squash <= 1, pend_pc <= redirect_pc, stay in S_REQ with the address unchanged.
- Squashed response (icache_resp && squash):
  - Discard the data; the slot stays empty.
  - pc_q <= pend_pc, squash <= 0, go to S_IDLE.
  - If a new redirect arrives in the same cycle, pc_q <= redirect_pc.
- Repeated redirects while squashed: the latest redirect_pc overwrites pend_pc.
- Slot hold: while stall_in is high and if_valid=1, all slot outputs hold their values.
- Reset mid-request: state returns to S_IDLE and the outstanding response is ignored.
  - icache_resp arriving in S_IDLE is always ignored.
- Wrap-around: PC arithmetic belongs to the predictor. A pred_pcmux_out of 0 after 32'hFFFFFFFC is accepted as-is.

Optional Feature:
- Macro: IF_FETCH_PERF_EN.
- Defined: adds output ports perf_fetched (32) and perf_squashed (32). Both are 32-bit counters, reset to 0, saturating at 32'hFFFFFFFF.
  - perf_fetched increments on each good response.
  - perf_squashed increments on each discarded response and on each valid slot cleared by a redirect.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- rv32i_types additions:
  - fetch_state_t enum {S_IDLE, S_REQ}
  - if_slot_t struct {valid, instr, pc, pred_target, pred_outcome, btb_hit}
- One sub-module, if_output_slot: a one-entry holding register with load/consume/flush inputs and the priority flush > load > consume.
  - The FSM and PC logic stay in the top.

Test Plan:
- Reset release, cache responds 1 cycle after read, pred_pcmux_out=pc+4 -> reads at 0x60 then 0x64; if_valid pulses with if_instr/if_pc correct; 3-cycle spacing.
- Good response with pred_pcmux_out=0x200, pred_outcome=2'b11, pred_btb_hit=1 -> slot shows outcome 11, hit 1, target 0x200; next read at 0x200.
- stall_in held high for 5 cycles with slot valid -> slot outputs stable, icache_read=0 throughout; fetch resumes 1 cycle after release.
- mem_misprediction with redirect_pc=0x400 while S_REQ at 0x80 and cache slow (resp 4 cycles later) -> address stays 0x80, response discarded, if_valid stays 0, next read at 0x400.
- Redirect in the same cycle as icache_resp and a slot consume -> slot cleared, data discarded, pc_q=redirect_pc.
- With IF_FETCH_PERF_EN: 10 good fetches plus 2 squashed responses -> perf_fetched=10, perf_squashed=2.
